adc_sequencer: RTL
==================

# adc_sequencer

Schedules conversions on the MAX10 built-in ADC command/response interface. A high-rate audio channel is interleaved with a round-robin set of slow housekeeping channels (battery, temperature, forward/reverse power). Results are routed to two streams: a free-running audio sample strobe for the transceiver datapath and a handshaked housekeeping word for the CPU. The block sits between the `adc` IP core and the transceiver/CPU input ports, in the `clk_10` domain.

## Interface
- AUDIO_CHANNEL, 1: ADC channel number sampled in normal slots.
- AUX_BASE, 2: first housekeeping channel number.
- AUX_COUNT, 4: number of housekeeping channels, AUX_BASE..AUX_BASE+AUX_COUNT-1; range 1..16.
- AUX_PERIOD, 8: every AUX_PERIOD-th issued command is a housekeeping slot; range 2..256.
- TIMEOUT, 255: maximum cycles in WAIT before a timeout error; range 1..65535.

- clk  in  1  ADC clock (clk_10).
- rst_n  in  1  asynchronous, active-low reset.
- enable_in  in  1  run the sequencer; low drains to IDLE.
- command_valid_out  out  1  Avalon-ST command valid.
- command_channel_out  out  5  channel being requested.
- command_startofpacket_out  out  1  equals command_valid_out.
- command_endofpacket_out  out  1  equals command_valid_out.
- command_ready_in  in  1  ADC accepts the command.
- response_valid_in  in  1  conversion result valid.
- response_channel_in  in  5  channel of the result.
- response_data_in  in  12  conversion result.
- audio_out  out  12  latest audio sample.
- audio_stb_out  out  1  one-cycle pulse when audio_out updates; no backpressure.
- aux_out  out  32  {11'b0, channel[4:0], 4'b0, data[11:0]}.
- aux_stb_out  out  1  housekeeping word valid.
- aux_ack_in  in  1  consumer accepts aux_out.
- aux_overflow_out  out  1  sticky: a pending aux word was overwritten.
- error_out  out  1  sticky: timeout or channel mismatch.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Exactly one command is outstanding at any time.
- IDLE: if enable_in, go to ISSUE. While in IDLE with enable_in low, clear aux_overflow_out and error_out.
- ISSUE: command_valid_out=1, channel held stable. On command_ready_in, go to WAIT, load the timeout counter with 0, and advance the slot scheduler. Once asserted, valid is never withdrawn, even if enable_in falls.
- WAIT: on response_valid_in, go to ISSUE if enable_in is high, otherwise IDLE. If the counter reaches TIMEOUT first, set error_out and take the same transition; a response arriving later is ignored unless the block is in WAIT.
- Slot scheduler: slot counter 0..AUX_PERIOD-1, wrapping. Slot AUX_PERIOD-1 issues channel AUX_BASE+aux_idx, then aux_idx advances modulo AUX_COUNT. All other slots issue AUDIO_CHANNEL.
- Response routing (WAIT only): if response_channel_in differs from the expected channel, set error_out and discard the data. Otherwise:
  - Audio: update audio_out and pulse audio_stb_out.
  - Aux: load aux_out and set aux_stb_out.
- Aux handshake: a word transfers when aux_stb_out && aux_ack_in, after which aux_stb_out clears the next cycle.
  - If a new aux result arrives while aux_stb_out is high and ack is low: overwrite aux_out, keep the strobe high, set aux_overflow_out.
  - If the new result coincides with ack: the old word is consumed, the new word is loaded, the strobe stays high, and no overflow is flagged.
- command_channel_out in IDLE holds its last value (AUDIO_CHANNEL after reset).

## Timing
- Reset values:
  - State IDLE; slot and aux_idx 0.
  - command_valid/sop/eop 0; command_channel_out=AUDIO_CHANNEL.
  - audio_out 0; audio_stb_out 0.
  - aux_out 0; aux_stb_out 0.
  - aux_overflow_out 0; error_out 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from an input to an output.
- enable_in rising in IDLE: command_valid_out high 1 cycle later.
- Response to output: audio_stb_out/aux_stb_out is high in the cycle after response_valid_in.
- Response to next command: valid is high in the cycle after the response, so an immediate-ready ADC gives a 2-cycle minimum loop when the response is concurrent.
- Timeout: error_out is set TIMEOUT+1 cycles after the command acceptance edge.
- Reset asserted mid-operation forces every register to its reset value immediately; an in-flight response after release is ignored because the state is IDLE.

## Test plan
- Defaults, ADC model with ready=1 and response 3 cycles after acceptance, enable high → command channels 1,1,1,1,1,1,1,2,1×7,3,1×7,4,1×7,5,1×7,2; aux_out channel fields 2,3,4,5,2.
- Response channel 1, data 12'hABC → audio_out=12'hABC and audio_stb_out high for exactly 1 cycle; error_out stays 0.
- Aux ack held low across two aux results (0x111 then 0x222) → aux_out data=0x222, aux_overflow_out=1; ack pulse clears the strobe; enable low for one cycle in IDLE clears the overflow flag.
- No response after acceptance, TIMEOUT=10 → error_out rises 11 cycles after acceptance, the next command issues, the slot counter has advanced by 1.
- Response channel 7 when 1 expected → error_out=1, audio_stb_out stays 0; enable dropped during ISSUE with ready low → valid held until ready, then WAIT, then IDLE.
- rst_n pulsed low during WAIT → all outputs at reset values the same cycle; the late response produces no strobe.

Source files
------------

// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sequencer
//  Purpose  : Drives the MAX10 ADC command/response interface. Audio
//             conversions are interleaved with a round-robin set of
//             housekeeping channels. Audio results leave as a free-running
//             sample strobe; housekeeping results leave as a handshaked
//             32-bit word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                        ADC clock (clk_10 domain)
//    rst_n                      asynchronous active-low reset
//    enable_in                  run the sequencer; low drains to IDLE
//    command_valid_out          command valid (one outstanding at a time)
//    command_channel_out[4:0]   requested channel
//    command_startofpacket_out  mirrors command_valid_out
//    command_endofpacket_out    mirrors command_valid_out
//    command_ready_in           ADC accepts the command
//    response_valid_in          conversion result valid
//    response_channel_in[4:0]   channel of the result
//    response_data_in[11:0]     conversion result
//    audio_out[11:0]            latest audio sample
//    audio_stb_out              one-cycle pulse on audio update
//    aux_out[31:0]              {11'b0, channel, 4'b0, data}
//    aux_stb_out                housekeeping word valid
//    aux_ack_in                 consumer accepts aux_out
//    aux_overflow_out           sticky: pending aux word was overwritten
//    error_out                  sticky: timeout or channel mismatch
// ============================================================================
module adc_sequencer #(
    parameter int AUDIO_CHANNEL = 1,
    parameter int AUX_BASE      = 2,
    parameter int AUX_COUNT     = 4,
    parameter int AUX_PERIOD    = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_in,
    output logic        command_valid_out,
    output logic [4:0]  command_channel_out,
    output logic        command_startofpacket_out,
    output logic        command_endofpacket_out,
    input  logic        command_ready_in,
    input  logic        response_valid_in,
    input  logic [4:0]  response_channel_in,
    input  logic [11:0] response_data_in,
    output logic [11:0] audio_out,
    output logic        audio_stb_out,
    output logic [31:0] aux_out,
    output logic        aux_stb_out,
    input  logic        aux_ack_in,
    output logic        aux_overflow_out,
    output logic        error_out
);

    localparam logic [4:0]  c_audio_ch  = 5'(AUDIO_CHANNEL);
    localparam logic [4:0]  c_aux_base  = 5'(AUX_BASE);
    localparam logic [7:0]  c_last_slot = 8'(AUX_PERIOD - 1);
    localparam logic [3:0]  c_last_aux  = 4'(AUX_COUNT - 1);
    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_slot;
    logic [3:0]  r_aux_idx;
    logic [15:0] r_timer;
    logic [4:0]  r_channel;
    logic        r_is_aux;
    logic [11:0] r_audio;
    logic        r_audio_stb;
    logic [31:0] r_aux;
    logic        r_aux_stb;
    logic        r_overflow;
    logic        r_error;

    // Channel the scheduler will hand out for the current slot. The slot
    // counter has already advanced by the time the next command is loaded.
    logic        w_sched_aux;
    logic [4:0]  w_sched_ch;

    assign w_sched_aux = (r_slot == c_last_slot);
    assign w_sched_ch  = w_sched_aux ? (c_aux_base + {1'b0, r_aux_idx}) : c_audio_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_slot      <= 8'd0;
            r_aux_idx   <= 4'd0;
            r_timer     <= 16'd0;
            r_channel   <= c_audio_ch;
            r_is_aux    <= 1'b0;
            r_audio     <= 12'd0;
            r_audio_stb <= 1'b0;
            r_aux       <= 32'd0;
            r_aux_stb   <= 1'b0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_audio_stb <= 1'b0;
            // A transfer retires the word; a concurrent new result below
            // re-asserts the strobe.
            if (r_aux_stb && aux_ack_in) begin
                r_aux_stb <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable_in) begin
                        r_state   <= S_ISSUE;
                        r_channel <= w_sched_ch;
                        r_is_aux  <= w_sched_aux;
                    end else begin
                        r_overflow <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end

                // Valid is held until accepted regardless of enable_in.
                S_ISSUE: begin
                    if (command_ready_in) begin
                        r_state <= S_WAIT;
                        r_timer <= 16'd0;
                        if (w_sched_aux) begin
                            r_slot    <= 8'd0;
                            r_aux_idx <= (r_aux_idx == c_last_aux) ? 4'd0 : r_aux_idx + 4'd1;
                        end else begin
                            r_slot <= r_slot + 8'd1;
                        end
                    end
                end

                S_WAIT: begin
                    if (response_valid_in || (r_timer == c_timeout)) begin
                        if (!response_valid_in || (response_channel_in != r_channel)) begin
                            r_error <= 1'b1;
                        end else if (r_is_aux) begin
                            r_aux     <= {11'd0, response_channel_in, 4'd0, response_data_in};
                            r_aux_stb <= 1'b1;
                            if (r_aux_stb && !aux_ack_in) begin
                                r_overflow <= 1'b1;
                            end
                        end else begin
                            r_audio     <= response_data_in;
                            r_audio_stb <= 1'b1;
                        end

                        if (enable_in) begin
                            r_state   <= S_ISSUE;
                            r_channel <= w_sched_ch;
                            r_is_aux  <= w_sched_aux;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign command_valid_out         = (r_state == S_ISSUE);
    assign command_startofpacket_out = (r_state == S_ISSUE);
    assign command_endofpacket_out   = (r_state == S_ISSUE);
    assign command_channel_out       = r_channel;
    assign audio_out                 = r_audio;
    assign audio_stb_out             = r_audio_stb;
    assign aux_out                   = r_aux;
    assign aux_stb_out               = r_aux_stb;
    assign aux_overflow_out          = r_overflow;
    assign error_out                 = r_error;

endmodule
`default_nettype wire
